muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-006 SHALL have port a, b  input  WIDTH  operands; a is multiplicand/dividend/move source, b is multiplier/divisor.
REQ-007 SHALL have port flush  input  1  abort in-flight operation (pipeline exception/kill).
REQ-008 SHALL have port hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-009 SHALL have port busy  output  1  high while an iterative operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo take a new mult/div result.
REQ-011 SHALL have port div0  output  1  sticky high from a divide-by-zero completion until the next accepted start.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; busy=1 exactly when state is not IDLE.
REQ-013 SHALL accept start only in IDLE; start while busy is ignored with no state change.
REQ-014 SHALL, on an accepting edge with MTHI/MTLO, write a into hi/lo on that edge, remain in IDLE, and leave done=0.
REQ-015 SHALL, on an accepting edge with MULT/MULTU/DIV/DIVU, latch operand magnitudes and signs, clear the counter, and enter CALC.
REQ-016 SHALL perform one radix-2 step per CALC cycle: shift-add for multiply, restoring shift-subtract for divide; CALC lasts exactly WIDTH cycles.
REQ-017 SHALL, in FIX, apply sign correction: signed product negated if sign(a)!=sign(b); quotient negated if signs differ; remainder takes sign of a.
REQ-018 SHALL, on the edge leaving FIX, write hi/lo (multiply: hi=upper, lo=lower half of 2*WIDTH product; divide: hi=remainder, lo=quotient), set done=1 for the following cycle, and return to IDLE.
REQ-019 SHALL give a latency of WIDTH+2 edges from the accepting edge to the edge that writes hi/lo.
REQ-020 SHALL hold hi/lo unchanged while busy; intermediate results are never visible.
REQ-021 SHALL accept a new start in the cycle where done=1 (back-to-back).
REQ-022 SHALL, for division with b=0, skip nothing (full latency), write lo=all ones, hi=a, set div0.
REQ-023 SHALL, for signed DIV of most-negative by -1, write lo=most-negative (wrap), hi=0, with no flag.
REQ-024 SHALL, on flush, return to IDLE on that edge, leave hi/lo and div0 unchanged, and suppress done; flush with start in IDLE suppresses acceptance (flush wins).
REQ-025 SHALL treat op 110/111 with start as accepted no-ops: no state or register change.

Reset
REQ-026 SHALL, on rst=1, immediately (asynchronously) force state IDLE, hi=0, lo=0, busy=0, done=0, div0=0, counter=0.
REQ-027 SHALL abandon an in-flight operation on reset with no done pulse after release.

Structure
REQ-028 SHALL take op encodings and state encodings from shared package muldiv_pkg, alongside the existing ALU control constants.
REQ-029 SHALL place the per-cycle multiply/divide iteration datapath in one sub-module, muldiv_step; control and HI/LO registers live in muldiv_unit.

Verification
REQ-030 SHALL cover: MULT a=0xFFFFFFFE (-2), b=3 -> after 34 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div0=1.
REQ-033 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-034 SHALL cover: MULT started, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values; start during busy ignored.
REQ-035 SHALL cover: MTHI a=0x1234 -> hi=0x1234 next cycle with done=0; rst asserted mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and ALU control constants
package muldiv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between pipeline and mul/div unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, op, a, b, flush,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  start, op, a, b, flush,
        output hi, lo, busy, done, div0
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: {acc,q} shifts right, low multiplier bit gates the add.
    assign w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});

    // Divide: partial remainder stays below the divisor, so the difference fits WIDTH bits.
    assign w_shift = {i_acc, i_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_m});
    assign w_diff  = w_shift[WIDTH-1:0] - i_m;

    always_comb begin
        o_acc = w_sum[WIDTH:1];
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        if (i_is_div) begin
            o_acc = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic               w_sgn;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_acc_n;
    logic [WIDTH-1:0]   w_q_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_sgn    = op_is_signed(bus.op);
    assign w_a_neg  = w_sgn & bus.a[WIDTH-1];
    assign w_b_neg  = w_sgn & bus.b[WIDTH-1];
    assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    // Most-negative magnitude is still exact as an unsigned WIDTH-bit value.
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_m      (r_m),
        .o_acc    (w_acc_n),
        .o_q      (w_q_n)
    );

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            case (md_op_e'(bus.op))
                                OP_MTHI: begin
                                    r_hi   <= bus.a;
                                    r_div0 <= 1'b0;
                                end
                                OP_MTLO: begin
                                    r_lo   <= bus.a;
                                    r_div0 <= 1'b0;
                                end
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    r_acc    <= '0;
                                    r_q      <= w_is_div ? w_a_mag : w_b_mag;
                                    r_m      <= w_is_div ? w_b_mag : w_a_mag;
                                    r_is_div <= w_is_div;
                                    r_neg_q  <= w_a_neg ^ w_b_neg;
                                    r_neg_r  <= w_a_neg;
                                    r_bz     <= w_is_div && (bus.b == '0);
                                    r_cnt    <= '0;
                                    r_div0   <= 1'b0;
                                    r_state  <= ST_CALC;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_CALC: begin
                        r_acc <= w_acc_n;
                        r_q   <= w_q_n;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH-1))
                            r_state <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= r_bz ? '1 : w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                        r_div0  <= r_is_div & r_bz;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.div0 = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        longint        sa, sb_;
        longint unsigned ua, ub;
        logic [63:0]   p, q, r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e = '0;
        case (op)
            3'b000: begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'b001: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.div0 = 1'b1;
                end else if (op == 3'b010) begin
                    q = sa / sb_; r = sa % sb_; e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    q = ua / ub;  r = ua % ub;  e.hi = r[31:0]; e.lo = q[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Issues one request from just after an edge and returns edges counted up to done.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 4*LAT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div0} !== '0)
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b div0=%b, want all 0",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div0);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [2:0]   ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b010};
        logic [W-1:0] as  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [W-1:0] bs  [5] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [W-1:0] ehi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'd0};
        logic [W-1:0] elo [5] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        logic         ed0 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{hi: ehi[i], lo: elo[i], div0: ed0[i]});
            run_op(ops[i], as[i], bs[i], lat);
            e = sb.pop_front();
            n_total++;
            if (lat != LAT) $display("FAIL vec%0d_latency: got %0d edges, want %0d", i, lat, LAT);
            else n_pass++;
            n_total++;
            if ({bus.hi, bus.lo, bus.div0} !== {e.hi, e.lo, e.div0})
                $display("FAIL vec%0d_result: got hi=%h lo=%h div0=%b, want hi=%h lo=%h div0=%b",
                         i, bus.hi, bus.lo, bus.div0, e.hi, e.lo, e.div0);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got done=%b, want 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_div0_sticky();
        int lat;
        run_op(3'b011, 32'd9, 32'd0, lat);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'hABCD; bus.b = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_total++;
        if ({bus.hi, bus.lo, bus.busy, bus.div0} !== {32'd9, 32'hFFFFFFFF, 1'b0, 1'b1})
            $display("FAIL nop_no_change: got hi=%h lo=%h busy=%b div0=%b, want hi=9 lo=ffffffff busy=0 div0=1",
                     bus.hi, bus.lo, bus.busy, bus.div0);
        else n_pass++;
        bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h55;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_total++;
        if ({bus.lo, bus.div0, bus.done, bus.busy} !== {32'h55, 1'b0, 1'b0, 1'b0})
            $display("FAIL mtlo_clears_div0: got lo=%h div0=%b done=%b busy=%b, want lo=55 div0=0 done=0 busy=0",
                     bus.lo, bus.div0, bus.done, bus.busy);
        else n_pass++;
    endtask

    task automatic test_move();
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_total++;
        if ({bus.hi, bus.lo, bus.done, bus.busy} !== {32'h1234, 32'h55, 1'b0, 1'b0})
            $display("FAIL mthi: got hi=%h lo=%h done=%b busy=%b, want hi=1234 lo=55 done=0 busy=0",
                     bus.hi, bus.lo, bus.done, bus.busy);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] phi, plo;
        exp_t e;
        int   lat;
        phi = bus.hi; plo = bus.lo;
        sb.push_back(model(3'b001, 32'd1000, 32'd77));
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd1000; bus.b = 32'd77;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 4*LAT) begin
            bus.start = (lat >= 5 && lat < 8);
            if (bus.start) begin bus.op = 3'b011; bus.a = 32'd5; bus.b = 32'd0; end
            @(posedge clk); #1;
            lat++;
            if (lat == 20) begin
                n_total++;
                if ({bus.hi, bus.lo, bus.busy} !== {phi, plo, 1'b1})
                    $display("FAIL hold_while_busy: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=1",
                             bus.hi, bus.lo, bus.busy, phi, plo);
                else n_pass++;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (lat != LAT || {bus.hi, bus.lo, bus.div0} !== {e.hi, e.lo, e.div0})
            $display("FAIL busy_start_ignored: got lat=%0d hi=%h lo=%h div0=%b, want lat=%0d hi=%h lo=%h div0=%b",
                     lat, bus.hi, bus.lo, bus.div0, LAT, e.hi, e.lo, e.div0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        exp_t e;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom();
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            if (i == 1) begin a = 32'h80000000; b = 32'h80000000; op = 3'b000; end
            sb.push_back(model(op, a, b));
            run_op(op, a, b, lat);
            e = sb.pop_front();
            n_total++;
            if (lat != LAT || {bus.hi, bus.lo, bus.div0} !== {e.hi, e.lo, e.div0})
                $display("FAIL b2b%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h div0=%b, want lat=%0d hi=%h lo=%h div0=%b",
                         i, op, a, b, lat, bus.hi, bus.lo, bus.div0, LAT, e.hi, e.lo, e.div0);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] phi, plo;
        logic         pd0;
        int           lat, seen;
        run_op(3'b001, 32'd3, 32'd5, lat);
        phi = bus.hi; plo = bus.lo; pd0 = bus.div0;
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd123; bus.b = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL flush_busy: got busy=%b, want 0", bus.busy);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 2*LAT; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0 || {bus.hi, bus.lo, bus.div0} !== {phi, plo, pd0})
            $display("FAIL flush_no_done: got done_cycles=%0d hi=%h lo=%h div0=%b, want 0 hi=%h lo=%h div0=%b",
                     seen, bus.hi, bus.lo, bus.div0, phi, plo, pd0);
        else n_pass++;
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b100; bus.a = 32'hDEAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_total++;
        if ({bus.hi, bus.busy} !== {phi, 1'b0})
            $display("FAIL flush_wins: got hi=%h busy=%b, want hi=%h busy=0", bus.hi, bus.busy, phi);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int seen;
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div0} !== '0)
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b div0=%b, want all 0",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div0);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 2*LAT; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL reset_abandons: got %0d cycles with done/busy, want 0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div0_sticky();
        test_move();
        test_busy_ignore();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
